rbm_vote_controller: RTL and testbench

//  Iterates a stochastic RBM network (hidden + classify layers) for a runtime-selected count of passes.

---
 rtl/rbm_vote_controller_pkg.sv | 19 +
 rtl/rbm_vote_controller_argmax_scan.sv | 30 +++
 rtl/rbm_vote_controller.sv | 166 ++++++++++++++++
 tb/tb_rbm_vote_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbm_vote_controller_pkg.sv
// Shared types and helpers for the RBM vote controller.
// FSM state encodings and the slice offset of a class counter in the packed counts bus.
package rbm_vote_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NRST  = 3'd1,
        S_RUN   = 3'd2,
        S_ACCUM = 3'd3,
        S_SCAN  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Class i occupies bits [i*w +: w] of the flat counts bus.
    function automatic int count_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rbm_vote_controller_argmax_scan.sv
// Sequential argmax: one candidate per step, strict compare so ties keep the lowest index.
module rbm_vote_controller_argmax_scan #(
    parameter int VAL_W = 12,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic [VAL_W-1:0] value,
    input  logic [IDX_W-1:0] index,
    output logic [IDX_W-1:0] best_idx,
    output logic [VAL_W-1:0] best_val
);

    // Best-so-far register pair; starts at (0, 0) so an all-zero scan reports class 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            best_idx <= {IDX_W{1'b0}};
            best_val <= {VAL_W{1'b0}};
        end else if (clear) begin
            best_idx <= {IDX_W{1'b0}};
            best_val <= {VAL_W{1'b0}};
        end else if (step && (value > best_val)) begin
            best_idx <= index;
            best_val <= value;
        end
    end

endmodule

// File: rtl/rbm_vote_controller.sv
// Runs the stochastic RBM for iter_target passes, accumulates per-class votes and reports the argmax.
// Optional build macro RBM_EARLY_STOP_EN ends the inference once any vote count reaches EARLY_THR.
module rbm_vote_controller
    import rbm_vote_controller_pkg::*;
#(
    parameter int OUTPUT_DIM = 10,
    parameter int COUNT_W    = 12,
    parameter int ITER_W     = 10,
    parameter int CLASS_W    = 4,
    parameter int EARLY_THR  = 20
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ITER_W-1:0]             iter_target,
    output logic                          busy,
    output logic                          net_reset,
    output logic                          net_data_valid,
    input  logic                          net_finish,
    input  logic [OUTPUT_DIM-1:0]         net_spikes,
    output logic [OUTPUT_DIM*COUNT_W-1:0] counts,
    output logic [ITER_W-1:0]             iter_done,
    output logic [CLASS_W-1:0]            winner,
    output logic                          early_stop,
    output logic                          result_valid,
    input  logic                          result_ready
);

    state_t                state_r, state_next_s;
    logic [ITER_W-1:0]     target_r, iter_done_r;
    logic [COUNT_W-1:0]    cnt_r      [OUTPUT_DIM];
    logic [COUNT_W-1:0]    cnt_next_s [OUTPUT_DIM];
    logic [OUTPUT_DIM-1:0] spikes_r;
    logic [CLASS_W-1:0]    scan_idx_r;
    logic                  busy_r, net_reset_r, net_data_valid_r, result_valid_r;
    logic                  last_pass_s, thr_hit_s, scan_last_s, start_ok_s;
    logic [COUNT_W-1:0]    best_val_s;

    assign start_ok_s  = (state_r == S_IDLE) && start;
    assign last_pass_s = ((iter_done_r + ITER_W'(1)) == target_r);
    assign scan_last_s = (scan_idx_r == CLASS_W'(OUTPUT_DIM - 1));

    // Saturating vote update from the spikes captured at the end of RUN, plus threshold detect.
    always_comb begin
        thr_hit_s = 1'b0;
        for (int i = 0; i < OUTPUT_DIM; i++) begin
            if (spikes_r[i] && (cnt_r[i] != {COUNT_W{1'b1}})) begin
                cnt_next_s[i] = cnt_r[i] + COUNT_W'(1);
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
`ifdef RBM_EARLY_STOP_EN
            if (int'(cnt_next_s[i]) >= EARLY_THR) begin
                thr_hit_s = 1'b1;
            end else begin
                thr_hit_s = thr_hit_s;
            end
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = (iter_target == {ITER_W{1'b0}}) ? S_DONE : S_NRST;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_NRST:  state_next_s = S_RUN;
            S_RUN:   state_next_s = net_finish ? S_ACCUM : S_RUN;
            S_ACCUM: state_next_s = (last_pass_s || thr_hit_s) ? S_SCAN : S_NRST;
            S_SCAN:  state_next_s = scan_last_s ? S_DONE : S_SCAN;
            S_DONE:  state_next_s = result_ready ? S_IDLE : S_DONE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, registered state-decoded outputs and the vote datapath.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r          <= S_IDLE;
            busy_r           <= 1'b0;
            net_reset_r      <= 1'b0;
            net_data_valid_r <= 1'b0;
            result_valid_r   <= 1'b0;
            target_r         <= {ITER_W{1'b0}};
            iter_done_r      <= {ITER_W{1'b0}};
            spikes_r         <= {OUTPUT_DIM{1'b0}};
            scan_idx_r       <= {CLASS_W{1'b0}};
            for (int i = 0; i < OUTPUT_DIM; i++) cnt_r[i] <= {COUNT_W{1'b0}};
        end else begin
            state_r          <= state_next_s;
            busy_r           <= (state_next_s != S_IDLE);
            net_reset_r      <= (state_next_s == S_NRST);
            net_data_valid_r <= (state_next_s == S_RUN);
            result_valid_r   <= (state_next_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        target_r    <= iter_target;
                        iter_done_r <= {ITER_W{1'b0}};
                        for (int i = 0; i < OUTPUT_DIM; i++) cnt_r[i] <= {COUNT_W{1'b0}};
                    end
                end
                S_RUN: begin
                    if (net_finish) spikes_r <= net_spikes;
                end
                S_ACCUM: begin
                    iter_done_r <= iter_done_r + ITER_W'(1);
                    scan_idx_r  <= {CLASS_W{1'b0}};
                    for (int i = 0; i < OUTPUT_DIM; i++) cnt_r[i] <= cnt_next_s[i];
                end
                S_SCAN:  scan_idx_r <= scan_idx_r + CLASS_W'(1);
                default: scan_idx_r <= scan_idx_r;
            endcase
        end
    end

`ifdef RBM_EARLY_STOP_EN
    logic early_stop_r;

    // Sticky until the next accepted start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            early_stop_r <= 1'b0;
        end else if (start_ok_s) begin
            early_stop_r <= 1'b0;
        end else if ((state_r == S_ACCUM) && thr_hit_s) begin
            early_stop_r <= 1'b1;
        end
    end

    assign early_stop = early_stop_r;
`else
    assign early_stop = 1'b0;
`endif

    rbm_vote_controller_argmax_scan #(
        .VAL_W (COUNT_W),
        .IDX_W (CLASS_W)
    ) u_scan (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_ok_s),
        .step     (state_r == S_SCAN),
        .value    (cnt_r[scan_idx_r]),
        .index    (scan_idx_r),
        .best_idx (winner),
        .best_val (best_val_s)
    );

    for (genvar gi = 0; gi < OUTPUT_DIM; gi++) begin : g_pack
        assign counts[count_lsb(gi, COUNT_W) +: COUNT_W] = cnt_r[gi];
    end

    assign busy           = busy_r;
    assign net_reset      = net_reset_r;
    assign net_data_valid = net_data_valid_r;
    assign result_valid   = result_valid_r;
    assign iter_done      = iter_done_r;

endmodule

// File: tb/tb_rbm_vote_controller.sv
// Directed bench for rbm_vote_controller: a default instance plus a 2-bit-counter instance.
module tb_rbm_vote_controller;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0, result_ready = 1'b0, net_finish = 1'b0;
    logic [9:0]   iter_target = 10'd0, net_spikes = 10'd0;
    logic         busy, net_reset, net_data_valid, early_stop, result_valid;
    logic [119:0] counts;
    logic [9:0]   iter_done;
    logic [3:0]   winner;

    logic         s_start = 1'b0, s_result_ready = 1'b0, s_net_finish = 1'b0;
    logic [9:0]   s_iter_target = 10'd0, s_net_spikes = 10'd0;
    logic         s_busy, s_net_reset, s_net_data_valid, s_early_stop, s_result_valid;
    logic [19:0]  s_counts;
    logic [9:0]   s_iter_done;
    logic [3:0]   s_winner;

    int           checks = 0, failures = 0;
    int           nrst_cnt = 0, pass_idx = 0, run_cnt = 0, s_run_cnt = 0;
    bit           manual_net = 1'b0;
    logic [9:0]   spk_tab [8];
    logic [9:0]   s_spk = 10'd0;

    always #5 clock = ~clock;

    rbm_vote_controller #(.EARLY_THR(4)) dut (
        .clock(clock), .reset(reset), .start(start), .iter_target(iter_target), .busy(busy),
        .net_reset(net_reset), .net_data_valid(net_data_valid), .net_finish(net_finish),
        .net_spikes(net_spikes), .counts(counts), .iter_done(iter_done), .winner(winner),
        .early_stop(early_stop), .result_valid(result_valid), .result_ready(result_ready));

    rbm_vote_controller #(.COUNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .start(s_start), .iter_target(s_iter_target), .busy(s_busy),
        .net_reset(s_net_reset), .net_data_valid(s_net_data_valid), .net_finish(s_net_finish),
        .net_spikes(s_net_spikes), .counts(s_counts), .iter_done(s_iter_done), .winner(s_winner),
        .early_stop(s_early_stop), .result_valid(s_result_valid), .result_ready(s_result_ready));

    // Network model for the main instance: finish two cycles into RUN with the spikes of the current pass.
    initial begin
        forever begin
            @(negedge clock);
            if (net_reset) nrst_cnt++;
            if (!manual_net) begin
                if (net_finish) begin
                    net_finish = 1'b0;
                    net_spikes = 10'd0;
                end else if (net_data_valid) begin
                    run_cnt++;
                    if (run_cnt >= 2) begin
                        net_finish = 1'b1;
                        net_spikes = (pass_idx < 8) ? spk_tab[pass_idx] : spk_tab[7];
                        pass_idx++;
                        run_cnt = 0;
                    end
                end else begin
                    run_cnt = 0;
                end
            end
        end
    end

    // Network model for the saturation instance.
    initial begin
        forever begin
            @(negedge clock);
            if (s_net_finish) begin
                s_net_finish = 1'b0;
                s_net_spikes = 10'd0;
            end else if (s_net_data_valid) begin
                s_run_cnt++;
                if (s_run_cnt >= 2) begin
                    s_net_finish = 1'b1;
                    s_net_spikes = s_spk;
                    s_run_cnt    = 0;
                end
            end else begin
                s_run_cnt = 0;
            end
        end
    end

    task automatic set_spikes(input logic [9:0] p);
        for (int i = 0; i < 8; i++) spk_tab[i] = p;
    endtask

    task automatic launch(input logic [9:0] tgt);
        @(negedge clock);
        nrst_cnt    = 0;
        pass_idx    = 0;
        iter_target = tgt;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        int n = 0;
        while (!result_valid && n < max) begin
            @(negedge clock);
            n++;
        end
        ok = result_valid;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, net_reset, net_data_valid, early_stop, result_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {busy, net_reset, net_data_valid, early_stop, result_valid});
        end
        checks++;
        if ({counts, iter_done, winner} !== 134'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {counts, iter_done, winner});
        end
        checks++;
        if ({s_busy, s_result_valid, s_counts, s_winner} !== 26'd0) begin
            failures++;
            $display("FAIL reset_sat got=%h exp=0", {s_busy, s_result_valid, s_counts, s_winner});
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_class();
        logic [119:0] exp_c = '0;
        bit ok;
        exp_c[24 +: 12] = 12'd3;
        set_spikes(10'b0000000100);
        launch(10'd3);
        repeat (3) @(negedge clock);
        start = 1'b1;
        iter_target = 10'd0;
        @(negedge clock);
        start = 1'b0;
        wait_valid(200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL t1_timeout got=%b exp=1", result_valid); end
        checks++;
        if (nrst_cnt != 3) begin failures++; $display("FAIL t1_nrst_pulses got=%0d exp=3", nrst_cnt); end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({result_valid, busy, counts, winner, iter_done} !== {1'b1, 1'b1, exp_c, 4'd2, 10'd3}) begin
                failures++;
                $display("FAIL t1_hold%0d got=%b/%b/%h/%0d/%0d exp=1/1/%h/2/3", c, result_valid, busy, counts, winner, iter_done, exp_c);
            end
            @(negedge clock);
        end
        accept();
        checks++;
        if ({result_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL t1_release got=%b exp=00", {result_valid, busy});
        end
    endtask

    task automatic test_zero_target();
        launch(10'd0);
        checks++;
        if ({result_valid, busy, winner, counts, iter_done} !== {1'b1, 1'b1, 4'd0, 120'd0, 10'd0}) begin
            failures++;
            $display("FAIL t2_zero got=%b/%b/%0d/%h/%0d exp=1/1/0/0/0", result_valid, busy, winner, counts, iter_done);
        end
        checks++;
        if (nrst_cnt != 0) begin failures++; $display("FAIL t2_nrst got=%0d exp=0", nrst_cnt); end
        accept();
    endtask

    task automatic test_argmax_last();
        logic [119:0] exp_c = '0;
        bit ok;
        exp_c[0 +: 12]   = 12'd1;
        exp_c[48 +: 12]  = 12'd1;
        exp_c[108 +: 12] = 12'd3;
        spk_tab[0] = 10'b1000000001;
        spk_tab[1] = 10'b1000000000;
        spk_tab[2] = 10'b1000010000;
        launch(10'd3);
        wait_valid(200, ok);
        checks++;
        if (!ok || counts !== exp_c || winner !== 4'd9) begin
            failures++;
            $display("FAIL argmax_last got=%b/%h/%0d exp=1/%h/9", ok, counts, winner, exp_c);
        end
        accept();
    endtask

    task automatic test_tie();
        logic [119:0] exp_c = '0;
        bit ok;
        exp_c[12 +: 12] = 12'd2;
        exp_c[60 +: 12] = 12'd2;
        set_spikes(10'b0000100010);
        launch(10'd2);
        wait_valid(200, ok);
        checks++;
        if (!ok || counts !== exp_c || winner !== 4'd1 || iter_done !== 10'd2) begin
            failures++;
            $display("FAIL t3_tie got=%b/%h/%0d/%0d exp=1/%h/1/2", ok, counts, winner, iter_done, exp_c);
        end
        accept();
        manual_net = 1'b1;
        net_spikes = 10'h3FF;
        net_finish = 1'b1;
        repeat (3) @(negedge clock);
        net_finish = 1'b0;
        net_spikes = 10'd0;
        manual_net = 1'b0;
        checks++;
        if (busy !== 1'b0 || net_data_valid !== 1'b0 || counts !== exp_c || iter_done !== 10'd2) begin
            failures++;
            $display("FAIL idle_finish got=%b/%b/%h/%0d exp=0/0/%h/2", busy, net_data_valid, counts, iter_done, exp_c);
        end
    endtask

    task automatic test_saturation();
        logic [19:0] exp_c = '0;
        int n = 0;
        exp_c[14 +: 2] = 2'd3;
        s_spk = 10'b0010000000;
        @(negedge clock);
        s_iter_target = 10'd6;
        s_start = 1'b1;
        @(negedge clock);
        s_start = 1'b0;
        while (!s_result_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!s_result_valid || s_counts !== exp_c || s_winner !== 4'd7 || s_iter_done !== 10'd6) begin
            failures++;
            $display("FAIL t4_sat got=%b/%h/%0d/%0d exp=1/%h/7/6", s_result_valid, s_counts, s_winner, s_iter_done, exp_c);
        end
        s_result_ready = 1'b1;
        @(negedge clock);
        s_result_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [119:0] exp_c = '0;
        bit ok;
        bit hit = 1'b0;
        exp_c[0 +: 12] = 12'd1;
        set_spikes(10'b0000000100);
        launch(10'd3);
        for (int n = 0; n < 100 && !hit; n++) begin
            @(posedge clock);
            #1;
            hit = (nrst_cnt == 2) && net_data_valid;
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL t5_reach_run got=%b exp=1", hit); end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, net_reset, net_data_valid, early_stop, result_valid, counts, iter_done, winner} !== 139'd0) begin
            failures++;
            $display("FAIL t5_abort got=%h exp=0", {busy, net_reset, net_data_valid, early_stop, result_valid, counts, iter_done, winner});
        end
        reset = 1'b1;
        set_spikes(10'b0000000001);
        launch(10'd1);
        wait_valid(100, ok);
        checks++;
        if (!ok || counts !== exp_c || iter_done !== 10'd1 || winner !== 4'd0) begin
            failures++;
            $display("FAIL t5_restart got=%b/%h/%0d/%0d exp=1/%h/1/0", ok, counts, iter_done, winner, exp_c);
        end
        accept();
    endtask

    task automatic test_early_stop();
        logic [119:0] exp_c = '0;
        bit ok;
        set_spikes(10'b0000001000);
        launch(10'd30);
        wait_valid(400, ok);
`ifdef RBM_EARLY_STOP_EN
        exp_c[36 +: 12] = 12'd4;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (!ok || result_valid !== 1'b1 || counts !== exp_c || winner !== 4'd3 || iter_done !== 10'd4 || early_stop !== 1'b1) begin
                failures++;
                $display("FAIL t6_early%0d got=%b/%h/%0d/%0d/%b exp=1/%h/3/4/1", c, result_valid, counts, winner, iter_done, early_stop, exp_c);
            end
            @(negedge clock);
        end
        accept();
        set_spikes(10'b0000000001);
        launch(10'd1);
        checks++;
        if (early_stop !== 1'b0) begin failures++; $display("FAIL t6_clear got=%b exp=0", early_stop); end
        wait_valid(100, ok);
        accept();
`else
        exp_c[36 +: 12] = 12'd30;
        checks++;
        if (!ok || counts !== exp_c || winner !== 4'd3 || iter_done !== 10'd30 || early_stop !== 1'b0) begin
            failures++;
            $display("FAIL full_run got=%b/%h/%0d/%0d/%b exp=1/%h/3/30/0", ok, counts, winner, iter_done, early_stop, exp_c);
        end
        accept();
`endif
    endtask

    initial begin
        set_spikes(10'd0);
        test_reset();
        test_single_class();
        test_zero_target();
        test_argmax_last();
        test_tie();
        test_saturation();
        test_reset_mid_run();
        test_early_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
